// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial W-bit adder, LSB first, one bit per clock. The optional
//            subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
// Revision : 1.0
// ============================================================================
module serial_adder #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start_in,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub_in,
`endif
    output logic         busy_out,
    output logic         done_out,
    output logic [W-1:0] sum_out,
    output logic         carry_out
);

    localparam int            CW     = $clog2(W + 1);
    localparam logic [1:0]    c_IDLE = 2'd0;
    localparam logic [1:0]    c_BUSY = 2'd1;
    localparam logic [1:0]    c_DONE = 2'd2;
    localparam logic [CW-1:0] c_LAST = CW'(W - 1);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;

    logic          w_sub;
    logic          w_ha1_s, w_ha1_c, w_ha2_c;
    logic          w_sum_bit, w_carry_bit;
    logic [W-1:0]  w_s_full;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub_in;
`else
    assign w_sub = 1'b0;
`endif

    // Full adder from two half-adder stages.
    assign w_ha1_s     = a_q[0] ^ b_q[0];
    assign w_ha1_c     = a_q[0] & b_q[0];
    assign w_sum_bit   = w_ha1_s ^ carry_q;
    assign w_ha2_c     = w_ha1_s & carry_q;
    assign w_carry_bit = w_ha1_c | w_ha2_c;

    // S keeps only the W-1 bits already produced; the current bit completes it.
    generate
        if (W == 1) begin : g_s_w1
            assign w_s_full = w_sum_bit;
        end else begin : g_s_wn
            logic [W-2:0] s_q, s_d;

            assign w_s_full = {w_sum_bit, s_q};

            always_comb begin
                s_d = s_q;
                if (state_q == c_BUSY) begin
                    s_d = w_s_full[W-1:1];
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    s_q <= '0;
                end else begin
                    s_q <= s_d;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            c_IDLE, c_DONE: begin
                if (start_in) begin
                    state_d = c_BUSY;
                    a_d     = a_in;
                    b_d     = w_sub ? ~b_in : b_in;
                    carry_d = w_sub ? 1'b1 : cin_in;
                    cnt_d   = '0;
                end else begin
                    state_d = c_IDLE;
                end
            end
            c_BUSY: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = w_carry_bit;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == c_LAST) begin
                    state_d = c_DONE;
                    sum_d   = w_s_full;
                    cout_d  = w_carry_bit;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= c_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy_out  = (state_q == c_BUSY);
    assign done_out  = (state_q == c_DONE);
    assign sum_out   = sum_q;
    assign carry_out = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// Testbench for serial_adder: scoreboard of expected {carry,sum} pushed on
// start and popped when done_out is observed.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b0;
    logic         start_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub_in = 1'b0;
`endif
    logic         busy_out;
    logic         done_out;
    logic [W-1:0] sum_out;
    logic         carry_out;

    logic [W:0]   exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk_in = ~clk_in;

    serial_adder #(.W(W)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .start_in  (start_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_in    (sub_in),
`endif
        .busy_out  (busy_out),
        .done_out  (done_out),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub);
        logic [W:0] e;
        a_in     = a;
        b_in     = b;
        cin_in   = cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub_in   = sub;
`endif
        start_in = 1'b1;
        if (sub) e = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     e = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        exp_q.push_back(e);
        @(posedge clk_in);
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    // Counts busy cycles until done_out; optionally scrambles inputs meanwhile.
    task automatic collect(input bit noise, output int nbusy, output bit seen,
                           output logic [W:0] res);
        nbusy = 0;
        seen  = 1'b0;
        res   = 'x;
        for (int i = 0; i < W + 6; i++) begin
            if (done_out) begin
                seen = 1'b1;
                res  = {carry_out, sum_out};
                break;
            end
            if (busy_out) nbusy++;
            if (noise) begin
                a_in     = W'($urandom);
                b_in     = W'($urandom);
                cin_in   = 1'($urandom);
                start_in = (i == 3);
            end
            @(negedge clk_in);
        end
        start_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        n_tests++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_out); end
        n_tests++; if (sum_out !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 00", sum_out); end
        n_tests++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b want 0", carry_out); end
    endtask

    task automatic test_add_basic();
        int nb; bit seen; logic [W:0] r; logic [W:0] e;
        drive_start(8'hFF, 8'h01, 1'b0, 1'b0);
        collect(1'b0, nb, seen, r);
        e = exp_q.pop_front();
        n_tests++; if (!seen) begin n_fail++; $display("FAIL add1_done: done_out not seen, want pulse"); end
        n_tests++; if (nb != W) begin n_fail++; $display("FAIL add1_busy_len: got %0d want %0d", nb, W); end
        n_tests++; if (r !== e || e !== 9'h100) begin n_fail++; $display("FAIL add1_result: got %h want %h", r, e); end
        @(negedge clk_in);
        n_tests++; if (done_out !== 1'b0 || busy_out !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got done=%b busy=%b want 0 0", done_out, busy_out); end

        drive_start(8'h3C, 8'h0F, 1'b0, 1'b0);
        collect(1'b0, nb, seen, r);
        e = exp_q.pop_front();
        n_tests++; if (!seen || r !== e) begin n_fail++; $display("FAIL add2_result: got %h want %h", r, e); end
        repeat (2) @(negedge clk_in);
        n_tests++; if (sum_out !== 8'h4B || carry_out !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got %b_%h want 0_4b", carry_out, sum_out); end
    endtask

    task automatic test_noise();
        int nb; bit seen; logic [W:0] r; logic [W:0] e;
        drive_start(8'h5A, 8'hA5, 1'b1, 1'b0);
        collect(1'b1, nb, seen, r);
        e = exp_q.pop_front();
        n_tests++; if (nb != W || !seen) begin n_fail++; $display("FAIL noise_timing: got busy=%0d done=%b want %0d 1", nb, seen, W); end
        n_tests++; if (r !== e) begin n_fail++; $display("FAIL noise_result: got %h want %h", r, e); end
        @(negedge clk_in);
    endtask

    task automatic test_back_to_back();
        int nb; bit seen; logic [W:0] r; logic [W:0] e;
        drive_start(8'h10, 8'h20, 1'b0, 1'b0);
        collect(1'b0, nb, seen, r);
        e = exp_q.pop_front();
        n_tests++; if (!seen || r !== e) begin n_fail++; $display("FAIL b2b_first: got %h want %h", r, e); end
        drive_start(8'h01, 8'h02, 1'b0, 1'b0);
        n_tests++; if (busy_out !== 1'b1 || done_out !== 1'b0) begin n_fail++; $display("FAIL b2b_no_bubble: got busy=%b done=%b want 1 0", busy_out, done_out); end
        n_tests++; if (sum_out !== 8'h30) begin n_fail++; $display("FAIL b2b_hold: got %h want 30", sum_out); end
        collect(1'b0, nb, seen, r);
        e = exp_q.pop_front();
        n_tests++; if (nb != W || !seen) begin n_fail++; $display("FAIL b2b_timing: got busy=%0d done=%b want %0d 1", nb, seen, W); end
        n_tests++; if (r !== e || r[W-1:0] !== 8'h03) begin n_fail++; $display("FAIL b2b_second: got %h want %h", r, e); end
        @(negedge clk_in);
    endtask

    task automatic test_reset_mid();
        int nb; bit seen; logic [W:0] r; logic [W:0] e; int ndone;
        drive_start(8'h77, 8'h11, 1'b0, 1'b0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        void'(exp_q.pop_back());
        n_tests++; if (busy_out !== 1'b0 || done_out !== 1'b0 || sum_out !== 8'h00 || carry_out !== 1'b0)
            begin n_fail++; $display("FAIL mid_reset_outputs: got busy=%b done=%b %b_%h want all 0", busy_out, done_out, carry_out, sum_out); end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_out) ndone++;
            @(negedge clk_in);
        end
        n_tests++; if (ndone != 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", ndone); end
        drive_start(8'h12, 8'h34, 1'b1, 1'b0);
        collect(1'b0, nb, seen, r);
        e = exp_q.pop_front();
        n_tests++; if (!seen || nb != W || r !== e) begin n_fail++; $display("FAIL mid_reset_fresh: got %h busy=%0d want %h busy=%0d", r, nb, e, W); end
        @(negedge clk_in);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int nb; bit seen; logic [W:0] r; logic [W:0] e;
        drive_start(8'h10, 8'h01, 1'b0, 1'b1);
        collect(1'b0, nb, seen, r);
        e = exp_q.pop_front();
        n_tests++; if (!seen || r !== e || r !== 9'h10F) begin n_fail++; $display("FAIL sub1: got %h want %h", r, e); end
        @(negedge clk_in);
        drive_start(8'h01, 8'h02, 1'b1, 1'b1);
        collect(1'b0, nb, seen, r);
        e = exp_q.pop_front();
        n_tests++; if (!seen || r !== e || r !== 9'h0FF) begin n_fail++; $display("FAIL sub2: got %h want %h", r, e); end
        sub_in = 1'b0;
        @(negedge clk_in);
    endtask
`endif

    initial begin
        @(negedge clk_in);
        test_reset();
        test_add_basic();
        test_noise();
        test_back_to_back();
        test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
